// File: rtl/dmc_dma_ctrl_pkg.sv
// Purpose : shared types and constants for the APU DMC sample-fetch DMA.
// Contents: FSM state enum, default bus base for DMC samples, address helper.
// Used by : dmc_dma_ctrl.
package dmc_dma_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        DUMMY = 3'd2,
        ALIGN = 3'd3,
        GET   = 3'd4,
        DATA  = 3'd5
    } dmc_dma_state_t;

    // DMC samples live in the upper half of the CPU address map.
    localparam logic [15:0] DMC_ADDR_BASE = 16'h8000;

    // The base is OR'd (not added) onto the 15-bit address, so bit 15 always
    // comes from the base and address wrap remains the APU's problem.
    function automatic logic [15:0] dmc_bus_addr(input logic [15:0] base,
                                                 input logic [14:0] addr);
        return base | {1'b0, addr};
    endfunction

endpackage

// File: rtl/dmc_dma_ctrl.sv
// Purpose : bus-side responder for APU DMC sample fetches; halts the CPU, does one bus read, returns the byte.
// Latency : dmc_re to dmc_data_valid is 4 CPU cycles, +1 for put-cycle alignment, +1 per CPU write seen while halting.
// Backpres: stalls the CPU via cpu_rdy and OAM DMA via oam_pause; dmc_re while busy is dropped, never queued.
// Ports   : clk/rst (async, active high); cpu_clk_en qualifies every state change;
//           APU side  dmc_re/dmc_addr in, dmc_read_data/dmc_data_valid out, apu_put_cycle in;
//           CPU side  cpu_rw in, cpu_rdy out; OAM side oam_dma_active in, oam_pause out;
//           bus side  bus_owner/bus_addr/bus_re out, bus_rd_data in; busy = request outstanding.
module dmc_dma_ctrl
    import dmc_dma_ctrl_pkg::*;
#(
    parameter logic [15:0] ADDR_BASE = DMC_ADDR_BASE,
    parameter bit          ALIGN_EN  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_clk_en,
    input  logic        apu_put_cycle,
    input  logic        dmc_re,
    input  logic [14:0] dmc_addr,
    output logic [7:0]  dmc_read_data,
    output logic        dmc_data_valid,
    input  logic        cpu_rw,
    output logic        cpu_rdy,
    input  logic        oam_dma_active,
    output logic        oam_pause,
    output logic        bus_owner,
    output logic [15:0] bus_addr,
    output logic        bus_re,
    input  logic [7:0]  bus_rd_data,
    output logic        busy
);

    dmc_dma_state_t state_q;
    dmc_dma_state_t state_d;
    logic [14:0]    addr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            addr_q         <= '0;
            dmc_read_data  <= '0;
            dmc_data_valid <= 1'b0;
        end else begin
            // Strobe lasts exactly one clk even if cpu_clk_en drops afterwards.
            dmc_data_valid <= 1'b0;
            if (cpu_clk_en) begin
                state_q <= state_d;
                // Only sampled in IDLE: a request while busy must not disturb
                // the address of the fetch already in flight.
                if (state_q == IDLE && dmc_re) begin
                    addr_q <= dmc_addr;
                end
                // bus_rd_data is valid on the enable following the GET read.
                if (state_q == DATA) begin
                    dmc_read_data  <= bus_rd_data;
                    dmc_data_valid <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cpu_rdy   = 1'b0;
        busy      = 1'b1;
        oam_pause = 1'b0;
        bus_owner = 1'b0;
        bus_re    = 1'b0;
        bus_addr  = 16'h0000;
        case (state_q)
            IDLE: begin
                cpu_rdy = 1'b1;
                busy    = 1'b0;
                if (dmc_re) begin
                    state_d = HALT;
                end
            end
            HALT: begin
                // The CPU ignores RDY on write cycles, so wait for a read.
                // An active OAM DMA already has the CPU halted.
                if (cpu_rw || oam_dma_active) begin
                    state_d = DUMMY;
                end
            end
            DUMMY: begin
                oam_pause = 1'b1;
                state_d   = (ALIGN_EN && apu_put_cycle) ? ALIGN : GET;
            end
            ALIGN: begin
                oam_pause = 1'b1;
                state_d   = GET;
            end
            GET: begin
                oam_pause = 1'b1;
                bus_owner = 1'b1;
                bus_re    = 1'b1;
                bus_addr  = dmc_bus_addr(ADDR_BASE, addr_q);
                state_d   = DATA;
            end
            DATA: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dmc_dma_ctrl.sv
// Directed bench for dmc_dma_ctrl: one instance with alignment enabled and
// one with it disabled, driven from the same inputs.
module tb_dmc_dma_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_clk_en;
    logic        apu_put_cycle;
    logic        dmc_re;
    logic [14:0] dmc_addr;
    logic        cpu_rw;
    logic        oam_dma_active;
    logic [7:0]  bus_rd_data;

    logic [7:0]  dmc_read_data;
    logic        dmc_data_valid;
    logic        cpu_rdy;
    logic        oam_pause;
    logic        bus_owner;
    logic [15:0] bus_addr;
    logic        bus_re;
    logic        busy;

    logic [7:0]  na_dmc_read_data;
    logic        na_dmc_data_valid;
    logic        na_cpu_rdy;
    logic        na_oam_pause;
    logic        na_bus_owner;
    logic [15:0] na_bus_addr;
    logic        na_bus_re;
    logic        na_busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dmc_dma_ctrl #(.ADDR_BASE(16'h8000), .ALIGN_EN(1'b1)) dut (
        .clk            (clk),
        .rst            (rst),
        .cpu_clk_en     (cpu_clk_en),
        .apu_put_cycle  (apu_put_cycle),
        .dmc_re         (dmc_re),
        .dmc_addr       (dmc_addr),
        .dmc_read_data  (dmc_read_data),
        .dmc_data_valid (dmc_data_valid),
        .cpu_rw         (cpu_rw),
        .cpu_rdy        (cpu_rdy),
        .oam_dma_active (oam_dma_active),
        .oam_pause      (oam_pause),
        .bus_owner      (bus_owner),
        .bus_addr       (bus_addr),
        .bus_re         (bus_re),
        .bus_rd_data    (bus_rd_data),
        .busy           (busy)
    );

    dmc_dma_ctrl #(.ADDR_BASE(16'h8000), .ALIGN_EN(1'b0)) dut_na (
        .clk            (clk),
        .rst            (rst),
        .cpu_clk_en     (cpu_clk_en),
        .apu_put_cycle  (apu_put_cycle),
        .dmc_re         (dmc_re),
        .dmc_addr       (dmc_addr),
        .dmc_read_data  (na_dmc_read_data),
        .dmc_data_valid (na_dmc_data_valid),
        .cpu_rw         (cpu_rw),
        .cpu_rdy        (na_cpu_rdy),
        .oam_dma_active (oam_dma_active),
        .oam_pause      (na_oam_pause),
        .bus_owner      (na_bus_owner),
        .bus_addr       (na_bus_addr),
        .bus_re         (na_bus_re),
        .bus_rd_data    (bus_rd_data),
        .busy           (na_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one request at edge 0, then runs 14 CPU cycles. Pattern bit k is
    // the input level during cycle k (cycle k sees the state after edge k-1).
    // Latency is counted in edges from the request edge to the strobe edge.
    task automatic run_fetch(input  logic [14:0] addr,
                             input  logic [7:0]  rdat,
                             input  logic [15:0] rw_pat,
                             input  logic [15:0] put_pat,
                             input  logic [15:0] oam_pat,
                             input  logic [15:0] re_pat,
                             output int          lat,
                             output int          lat_na,
                             output logic [15:0] addr_seen,
                             output int          rdy_low,
                             output int          nvalid,
                             output int          re_wr,
                             output logic [15:0] pause_mask);
        lat = -1; lat_na = -1; addr_seen = '0; rdy_low = 0;
        nvalid = 0; re_wr = 0; pause_mask = '0;
        cpu_rw = rw_pat[0]; apu_put_cycle = put_pat[0]; oam_dma_active = oam_pat[0];
        bus_rd_data = rdat; dmc_addr = addr; dmc_re = 1'b1;
        tick();
        for (int k = 1; k < 15; k++) begin
            cpu_rw         = rw_pat[k];
            apu_put_cycle  = put_pat[k];
            oam_dma_active = oam_pat[k];
            dmc_re         = re_pat[k];
            dmc_addr       = re_pat[k] ? 15'h0001 : addr;
            #1;
            if (!cpu_rdy) rdy_low++;
            if (oam_pause) pause_mask[k] = 1'b1;
            if (bus_re) begin
                addr_seen = bus_addr;
                if (!cpu_rw) re_wr++;
            end
            if (dmc_data_valid) begin
                nvalid++;
                if (lat < 0) lat = k - 1;
            end
            if (na_dmc_data_valid && lat_na < 0) lat_na = k - 1;
            tick();
        end
        dmc_re = 1'b0; cpu_rw = 1'b1; apu_put_cycle = 1'b0; oam_dma_active = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat, lat_na, rdy_low, nvalid, re_wr;
        logic [15:0] addr_seen, pmask;

        rst = 1'b1; cpu_clk_en = 1'b1; apu_put_cycle = 1'b0; dmc_re = 1'b0;
        dmc_addr = '0; cpu_rw = 1'b1; oam_dma_active = 1'b0; bus_rd_data = '0;
        tick(); tick();
        check("rst_cpu_rdy",   cpu_rdy, 1);
        check("rst_busy",      busy, 0);
        check("rst_bus_owner", bus_owner, 0);
        check("rst_bus_re",    bus_re, 0);
        check("rst_bus_addr",  bus_addr, 16'h0000);
        check("rst_data",      dmc_read_data, 8'h00);
        check("rst_valid",     dmc_data_valid, 0);
        check("rst_oam_pause", oam_pause, 0);
        rst = 1'b0;
        tick();

        // Basic fetch
        run_fetch(15'h4000, 8'hA5, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000,
                  lat, lat_na, addr_seen, rdy_low, nvalid, re_wr, pmask);
        check("basic_lat",     lat, 4);
        check("basic_addr",    addr_seen, 16'hC000);
        check("basic_rdy_low", rdy_low, 4);
        check("basic_nvalid",  nvalid, 1);
        check("basic_data",    dmc_read_data, 8'hA5);
        check("basic_pause",   pmask, 16'h000C);
        check("basic_lat_na",  lat_na, 4);
        tick(); tick(); tick();
        check("hold_data",  dmc_read_data, 8'hA5);
        check("hold_valid", dmc_data_valid, 0);

        // Two CPU writes while halting
        run_fetch(15'h0123, 8'h11, 16'hFFF9, 16'h0000, 16'h0000, 16'h0000,
                  lat, lat_na, addr_seen, rdy_low, nvalid, re_wr, pmask);
        check("wr_lat",     lat, 6);
        check("wr_rdy_low", rdy_low, 6);
        check("wr_re_wr",   re_wr, 0);
        check("wr_addr",    addr_seen, 16'h8123);
        check("wr_data",    dmc_read_data, 8'h11);

        // Put cycle at DUMMY: aligned instance waits one extra cycle
        run_fetch(15'h7FFF, 8'h96, 16'hFFFF, 16'h0004, 16'h0000, 16'h0000,
                  lat, lat_na, addr_seen, rdy_low, nvalid, re_wr, pmask);
        check("align_lat",    lat, 5);
        check("align_lat_na", lat_na, 4);
        check("align_pause",  pmask, 16'h001C);
        check("align_addr",   addr_seen, 16'hFFFF);
        check("align_data_na", na_dmc_read_data, 8'h96);

        // OAM active, CPU writing: HALT exits at once
        run_fetch(15'h0042, 8'hC3, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000,
                  lat, lat_na, addr_seen, rdy_low, nvalid, re_wr, pmask);
        check("oam_lat",   lat, 4);
        check("oam_pause", pmask, 16'h000C);
        check("oam_data",  dmc_read_data, 8'hC3);

        run_fetch(15'h0042, 8'h3D, 16'h0000, 16'h0004, 16'hFFFF, 16'h0000,
                  lat, lat_na, addr_seen, rdy_low, nvalid, re_wr, pmask);
        check("oam_align_lat",   lat, 5);
        check("oam_align_pause", pmask, 16'h001C);

        // Requests while busy are dropped
        run_fetch(15'h1234, 8'h3C, 16'hFFFF, 16'h0000, 16'h0000, 16'h0014,
                  lat, lat_na, addr_seen, rdy_low, nvalid, re_wr, pmask);
        check("b2b_lat",    lat, 4);
        check("b2b_addr",   addr_seen, 16'h9234);
        check("b2b_nvalid", nvalid, 1);
        check("b2b_data",   dmc_read_data, 8'h3C);
        check("b2b_busy",   busy, 0);

        // Request with cpu_clk_en low is not sampled
        cpu_clk_en = 1'b0; dmc_re = 1'b1; dmc_addr = 15'h0005;
        tick(); tick();
        check("noen_busy", busy, 0);
        check("noen_rdy",  cpu_rdy, 1);
        dmc_re = 1'b0; cpu_clk_en = 1'b1;
        tick();

        // State holds while cpu_clk_en is low
        bus_rd_data = 8'h5A; dmc_addr = 15'h0010; dmc_re = 1'b1; cpu_rw = 1'b1;
        tick();
        dmc_re = 1'b0; cpu_clk_en = 1'b0;
        tick(); tick(); tick();
        check("stall_rdy",   cpu_rdy, 0);
        check("stall_pause", oam_pause, 0);
        cpu_clk_en = 1'b1;
        tick(); tick(); tick(); tick(); tick();
        check("stall_busy", busy, 0);
        check("stall_data", dmc_read_data, 8'h5A);

        // Reset during GET
        bus_rd_data = 8'h77; dmc_addr = 15'h0200; dmc_re = 1'b1; cpu_rw = 1'b1;
        tick();
        dmc_re = 1'b0;
        tick(); tick();
        check("rget_owner_pre", bus_owner, 1);
        check("rget_addr_pre",  bus_addr, 16'h8200);
        rst = 1'b1;
        tick();
        check("rget_rdy",   cpu_rdy, 1);
        check("rget_owner", bus_owner, 0);
        check("rget_busy",  busy, 0);
        check("rget_valid", dmc_data_valid, 0);
        check("rget_data",  dmc_read_data, 8'h00);
        rst = 1'b0;
        tick(); tick();
        check("rget_after_valid", dmc_data_valid, 0);
        check("rget_after_busy",  busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dmc_dma_ctrl.md
Name: dmc_dma_ctrl

Overview:
- Bus-side responder for the APU DMC sample-fetch interface.
- Accepts the DMC read request and 15-bit sample address from the APU.
- Stalls the CPU through RDY, waits for a legal halt point and get-cycle alignment, then performs one CPU-bus read at ADDR_BASE | addr.
- Returns the byte to the APU with a one-cycle valid strobe. Sits between the APU and the CPU/bus mux, alongside OAM DMA.

Parameters:
ADDR_BASE, 16'h8000, base OR'd onto the 15-bit DMC address to form the bus address
ALIGN_EN, 1, 1 = enforce get-cycle alignment (extra wait on put cycles); 0 = skip the ALIGN state

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
cpu_clk_en  input  1  CPU-cycle enable; all state advances only when high
apu_put_cycle  input  1  high during APU put (odd) cycles
dmc_re  input  1  DMC read request pulse from the APU
dmc_addr  input  15  DMC sample address, valid with dmc_re
dmc_read_data  output  8  fetched sample byte to the APU
dmc_data_valid  output  1  one cpu_clk_en-qualified strobe when dmc_read_data is new
cpu_rw  input  1  CPU current cycle direction (1 = read)
cpu_rdy  output  1  CPU ready; 0 = halt request
oam_dma_active  input  1  OAM DMA currently owns the bus
oam_pause  output  1  OAM DMA must hold its current step this cycle
bus_owner  output  1  1 = this block drives the bus
bus_addr  output  16  bus address during the GET state
bus_re  output  1  bus read strobe
bus_rd_data  input  8  bus read data, valid on the cpu_clk_en after bus_re
busy  output  1  request outstanding

Behaviour:
- Reset values (async on rst): state IDLE; cpu_rdy=1; all other outputs 0, including dmc_read_data=8'h00, bus_addr=16'h0000, busy=0.
- State encoding and transitions are evaluated only when cpu_clk_en=1:
  - IDLE: on dmc_re, latch addr_q=dmc_addr, busy=1, go to HALT.
  - HALT: cpu_rdy=0. If cpu_rw=1 this cycle, go to DUMMY; otherwise stay. The CPU may complete write cycles; up to 3 consecutive writes are tolerated.
  - DUMMY: one cycle with cpu_rdy=0. Next is ALIGN if ALIGN_EN and apu_put_cycle=1, else GET.
  - ALIGN: one cycle, then GET.
  - GET: bus_owner=1, bus_re=1, bus_addr=ADDR_BASE | {1'b0,addr_q}; then go to DATA.
  - DATA: capture bus_rd_data into dmc_read_data, pulse dmc_data_valid, deassert bus_owner; then go to IDLE with cpu_rdy=1 and busy=0.
- cpu_rdy is 0 in every state except IDLE. It rises in the same cycle the state returns to IDLE.
- Latency: dmc_re to dmc_data_valid is 4 cpu cycles minimum (HALT→DUMMY→GET→DATA) with no CPU writes and no alignment.
  - Add 1 cycle for ALIGN.
  - Add 1 cycle per CPU write cycle seen in HALT.
- dmc_re while busy=1 is ignored. addr_q is not updated, and no second fetch is queued.
- dmc_re with cpu_clk_en=0 is not sampled.
- OAM interaction: when oam_dma_active=1, HALT does not wait on cpu_rw; the read condition is treated as met. oam_pause=1 during the DUMMY, ALIGN and GET states so that OAM yields its bus slot.
- Address arithmetic: bus_addr bit 15 always comes from ADDR_BASE[15]. There is no wrap handling here; the APU owns address wrap.
- dmc_read_data holds its last value until the next DATA state.
- rst mid-transfer: the FSM returns to IDLE immediately. cpu_rdy=1, bus_owner=0, and no valid strobe is issued.
- When cpu_clk_en=0, every output holds its value. dmc_data_valid is high only for the single clk on which DATA completes with cpu_clk_en=1.

Decomposition:
- Shared apu package: dmc_dma_state_t enum (IDLE, HALT, DUMMY, ALIGN, GET, DATA) and DMC_ADDR_BASE constant.
- Single module; no sub-module is warranted. addr_q and the data register use the existing apu_register with an active-high reset wrapper.

Test Plan:
- Basic fetch: dmc_re with addr 15'h4000, cpu_rw=1, put=0, bus_rd_data=8'hA5 → bus_addr=16'hC000 in GET; dmc_data_valid 4 cpu cycles after request with data 8'hA5; cpu_rdy low for exactly 4 cycles.
- CPU writes: 2 consecutive cpu_rw=0 cycles in HALT → valid at 6 cycles; bus_re is never asserted while cpu_rw=0.
- Alignment: apu_put_cycle=1 at DUMMY, ALIGN_EN=1 → valid at 5 cycles. Same stimulus with ALIGN_EN=0 → 4 cycles.
- OAM overlap: oam_dma_active=1 and cpu_rw=0 → HALT exits immediately; oam_pause=1 for DUMMY, (ALIGN) and GET only.
- Back-to-back: second dmc_re with addr 15'h0001 while busy → ignored; bus_addr stays at the first address, and only one valid strobe occurs.
- Reset mid-GET: rst pulsed during GET → next clk shows cpu_rdy=1, bus_owner=0, busy=0, dmc_data_valid=0, dmc_read_data=8'h00.
